// File: rtl/mem_pkg.sv
// Shared types and default geometry for the NAND-latch array controller.
package mem_pkg;

    localparam int unsigned DEF_ROWS  = 16;
    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; pointer flips to the other port after every grant.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic advance_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    port_id_t ptr_q;
    port_id_t ptr_d;

    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        if (req_a_i && req_b_i) begin
            gnt_a_o = (ptr_q == PORT_A);
            gnt_b_o = (ptr_q == PORT_B);
        end else begin
            gnt_a_o = req_a_i;
            gnt_b_o = req_b_i;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = gnt_a_o ? PORT_B : PORT_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_array_ctrl.sv
// Glitch-safe access sequencer for the NAND-latch bitcell array, shared by two ports.
module mem_array_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned WR_PULSE = 1,
    parameter int unsigned RD_WAIT  = 1,
    localparam int unsigned ADDR_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [WIDTH-1:0]  a_req_wdata,
    output logic              a_rsp_valid,
    output logic [WIDTH-1:0]  a_rsp_rdata,
    output logic              a_rsp_err,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [WIDTH-1:0]  b_req_wdata,
    output logic              b_rsp_valid,
    output logic [WIDTH-1:0]  b_rsp_rdata,
    output logic              b_rsp_err,

    output logic [ROWS-1:0]   row_sel,
    output logic              mem_rw,
    output logic [WIDTH-1:0]  mem_din,
    input  logic [WIDTH-1:0]  mem_dout_n
);

    localparam int unsigned MAX_PULSE = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
    localparam int unsigned CNT_W     = $clog2(MAX_PULSE + 1);

    state_t              state_q,   state_d;
    port_id_t            port_q,    port_d;
    logic                we_q,      we_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                err_q,     err_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0]    rdata_q,   rdata_d;
    logic [ROWS-1:0]     row_sel_q, row_sel_d;
    logic                mem_rw_q,  mem_rw_d;
    logic [WIDTH-1:0]    mem_din_q, mem_din_d;
    logic                a_rsp_valid_q, a_rsp_valid_d;
    logic [WIDTH-1:0]    a_rsp_rdata_q, a_rsp_rdata_d;
    logic                a_rsp_err_q,   a_rsp_err_d;
    logic                b_rsp_valid_q, b_rsp_valid_d;
    logic [WIDTH-1:0]    b_rsp_rdata_q, b_rsp_rdata_d;
    logic                b_rsp_err_q,   b_rsp_err_d;

    logic                gnt_a_c;
    logic                gnt_b_c;
    logic                idle_c;
    logic                accept_c;
    logic                req_we_c;
    logic [ADDR_W-1:0]   req_addr_c;
    logic [WIDTH-1:0]    req_wdata_c;
    logic [CNT_W-1:0]    pulse_last_c;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_a_i   (a_req_valid),
        .req_b_i   (b_req_valid),
        .advance_i (accept_c),
        .gnt_a_o   (gnt_a_c),
        .gnt_b_o   (gnt_b_c)
    );

    // Ready is offered only while idle and never during reset.
    assign idle_c      = (state_q == IDLE) && !rst;
    assign a_req_ready = idle_c && gnt_a_c;
    assign b_req_ready = idle_c && gnt_b_c;
    assign accept_c    = a_req_ready || b_req_ready;

    assign req_we_c    = gnt_a_c ? a_req_we    : b_req_we;
    assign req_addr_c  = gnt_a_c ? a_req_addr  : b_req_addr;
    assign req_wdata_c = gnt_a_c ? a_req_wdata : b_req_wdata;

    assign pulse_last_c = we_q ? CNT_W'(WR_PULSE - 1) : CNT_W'(RD_WAIT - 1);

    // rw/din only move at the accept and recover edges, where row_sel is already low.
    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        we_d          = we_q;
        addr_d        = addr_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        row_sel_d     = row_sel_q;
        mem_rw_d      = mem_rw_q;
        mem_din_d     = mem_din_q;
        a_rsp_valid_d = 1'b0;
        a_rsp_rdata_d = a_rsp_rdata_q;
        a_rsp_err_d   = a_rsp_err_q;
        b_rsp_valid_d = 1'b0;
        b_rsp_rdata_d = b_rsp_rdata_q;
        b_rsp_err_d   = b_rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d   = SETUP;
                    port_d    = gnt_a_c ? PORT_A : PORT_B;
                    we_d      = req_we_c;
                    addr_d    = req_addr_c;
                    err_d     = (32'(req_addr_c) >= ROWS);
                    rdata_d   = '0;
                    mem_rw_d  = req_we_c;
                    mem_din_d = req_we_c ? req_wdata_c : '0;
                end
            end
            SETUP: begin
                state_d   = STROBE;
                cnt_d     = '0;
                row_sel_d = err_q ? '0 : (ROWS'(1) << addr_q);
            end
            STROBE: begin
                if (cnt_q == pulse_last_c) begin
                    state_d   = RECOVER;
                    row_sel_d = '0;
                    if (!we_q && !err_q) begin
                        rdata_d = ~mem_dout_n;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                state_d   = IDLE;
                mem_rw_d  = 1'b0;
                mem_din_d = '0;
                if (port_q == PORT_A) begin
                    a_rsp_valid_d = 1'b1;
                    a_rsp_rdata_d = rdata_q;
                    a_rsp_err_d   = err_q;
                end else begin
                    b_rsp_valid_d = 1'b1;
                    b_rsp_rdata_d = rdata_q;
                    b_rsp_err_d   = err_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            port_q        <= PORT_A;
            we_q          <= 1'b0;
            addr_q        <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            row_sel_q     <= '0;
            mem_rw_q      <= 1'b0;
            mem_din_q     <= '0;
            a_rsp_valid_q <= 1'b0;
            a_rsp_rdata_q <= '0;
            a_rsp_err_q   <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_rdata_q <= '0;
            b_rsp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            row_sel_q     <= row_sel_d;
            mem_rw_q      <= mem_rw_d;
            mem_din_q     <= mem_din_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            a_rsp_rdata_q <= a_rsp_rdata_d;
            a_rsp_err_q   <= a_rsp_err_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            b_rsp_rdata_q <= b_rsp_rdata_d;
            b_rsp_err_q   <= b_rsp_err_d;
        end
    end

    assign row_sel     = row_sel_q;
    assign mem_rw      = mem_rw_q;
    assign mem_din     = mem_din_q;
    assign a_rsp_valid = a_rsp_valid_q;
    assign a_rsp_rdata = a_rsp_rdata_q;
    assign a_rsp_err   = a_rsp_err_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign b_rsp_rdata = b_rsp_rdata_q;
    assign b_rsp_err   = b_rsp_err_q;

endmodule
